// File: rtl/coeff_block_buffer_pkg.sv
// coeff_block_buffer_pkg: shared sizes, line type and control states for the block buffer
package coeff_block_buffer_pkg;
  localparam int BLOCK_BUFF_SIZE = 64;
  localparam int Q = 16;
  localparam int NUM_COMP = 3;
  localparam int ZRL_RUN = 15;
  typedef logic [BLOCK_BUFF_SIZE-1:0][Q-1:0] coeff_line_t;
  typedef enum logic {FILL, OUT} state_t;
endpackage

// File: rtl/dc_predictor.sv
// dc_predictor: per-component DC predictors turning a DC difference into an absolute DC value
module dc_predictor
  import coeff_block_buffer_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         upd,
  input  logic [1:0]   comp,
  input  logic [Q-1:0] diff,
  output logic [Q-1:0] dc
);
  logic [Q-1:0] pred [NUM_COMP];
  logic [Q-1:0] base;
  // a clear in the same cycle as a DC symbol makes that symbol predict from zero
  always_comb begin
    base = clear ? '0 : comp == 2'd1 ? pred[1] : comp == 2'd2 ? pred[2] : pred[0];
    dc = base + diff;
  end
  // the updated component keeps the new DC, the others are wiped by clear
  always_ff @(posedge clock)
    for (int i = 0; i < NUM_COMP; i++)
      pred[i] <= reset ? '0 : upd && comp == 2'(i) ? dc : clear ? '0 : pred[i];
endmodule

// File: rtl/coeff_block_buffer.sv
// coeff_block_buffer: builds one zigzag-ordered coefficient block from run/level symbols
module coeff_block_buffer
  import coeff_block_buffer_pkg::*;
(
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                restart,
  input  logic                                sym_valid,
  output logic                                sym_ready,
  input  logic                                sym_eob,
  input  logic [3:0]                          sym_run,
  input  logic [Q-1:0]                        sym_coeff,
  input  logic [1:0]                          sym_comp,
  output logic                                blk_valid,
  input  logic                                blk_ready,
  output logic [BLOCK_BUFF_SIZE-1:0][Q-1:0]   blk_line,
  output logic [1:0]                          blk_comp,
  output logic                                err
);
  state_t state;
  logic [6:0] idx;
  logic [6:0] p;
  logic [1:0] comp;
  logic [Q-1:0] dc;
  logic dc_acc;
  // handshake flags come straight from the state register
  always_comb begin
    sym_ready = state == FILL;
    blk_valid = state == OUT;
    p = idx + 7'(sym_run);
    comp = sym_comp == 2'd3 ? 2'd0 : sym_comp;
    dc_acc = state == FILL && sym_valid && !sym_eob && idx == 7'd0;
  end
  dc_predictor u_pred (
    .clock (clock),
    .reset (reset),
    .clear (restart),
    .upd   (dc_acc),
    .comp  (comp),
    .diff  (sym_coeff),
    .dc    (dc)
  );
  // FILL accumulates symbols into the line; OUT holds it until downstream takes it
  always_ff @(posedge clock)
    if (reset) begin
      state <= FILL;
      idx <= '0;
      blk_line <= '0;
      blk_comp <= '0;
      err <= 1'b0;
    end else if (state == OUT) begin
      if (blk_ready) begin
        state <= FILL;
        idx <= '0;
        blk_line <= '0;
      end
    end else if (sym_valid) begin
      if (sym_eob) begin
        if (idx == 7'd0) err <= 1'b1;
        else state <= OUT;
      end else if (idx == 7'd0) begin
        blk_line[0] <= dc;
        blk_comp <= comp;
        idx <= 7'd1;
        err <= err | (sym_comp == 2'd3);
      end else if (p[6]) begin
        err <= 1'b1;
        state <= OUT;
      end else begin
        blk_line[p[5:0]] <= sym_coeff;
        idx <= p + 7'd1;
        if (p == 7'd63) state <= OUT;
      end
    end
endmodule

// File: doc/coeff_block_buffer.md
# coeff_block_buffer

Assembles one 64-coefficient zigzag-ordered block from the run/level symbol stream produced by the Huffman/entropy decoder. Applies per-component DC prediction, expands zero runs and ZRL, closes the block on EOB or on the 64th coefficient, and presents the finished line to `unzigzag` through a valid/ready handshake. Sits directly upstream of `unzigzag`: its `blk_line` output is `unzigzag`'s `line` input.

## Interface
- `BLOCK_BUFF_SIZE`, 64, coefficients per block (from `sys_defs.svh`)
- `Q`, from `sys_defs.svh`, coefficient width in bits, signed two's complement
- `clock` in 1: single clock; all state changes on posedge
- `reset` in 1: synchronous, active-high
- `restart` in 1: one-cycle pulse; clears all DC predictors (restart marker)
- `sym_valid` in 1: symbol present
- `sym_ready` out 1: symbol accepted when `sym_valid && sym_ready`
- `sym_eob` in 1: symbol is End-Of-Block; `sym_run`/`sym_coeff` ignored
- `sym_run` in 4: zero run preceding the coefficient (ZRL = run 15, coeff 0)
- `sym_coeff` in Q, signed: AC value, or DC difference for the first symbol
- `sym_comp` in 2: component id 0..2, sampled on the DC symbol
- `blk_valid` out 1: `blk_line` holds a complete block
- `blk_ready` in 1: downstream accepts the block
- `blk_line` out `[BLOCK_BUFF_SIZE-1:0][Q-1:0]`: zigzag-ordered coefficients, index 0 = DC
- `blk_comp` out 2: component id of the block on `blk_line`
- `err` out 1: sticky protocol error; cleared only by `reset`

## Operation
- States: FILL, OUT. Reset: FILL, `idx`=0, line all zero, predictors 0, `blk_valid`=0, `blk_comp`=0, `err`=0.
- `sym_ready` = (state == FILL); `blk_valid` = (state == OUT).
- FILL, `idx`==0, accepted non-EOB symbol (DC): `line[0]` = pred[comp] + `sym_coeff` (Q-bit wrap). pred[comp] ← that value. `blk_comp` ← comp. `sym_run` ignored. `idx` ← 1.
- FILL, `idx`>0, accepted non-EOB symbol: `p` = `idx` + `sym_run`.
  - If `p` ≤ 63: `line[p]` = `sym_coeff`; `idx` ← `p`+1.
  - If `p` > 63: write dropped, `err` ← 1, block closes.
  - If new `idx` == 64, block closes.
- Accepted EOB with `idx`>0: block closes; unwritten positions remain zero.
- Accepted EOB with `idx`==0: no block emitted, `err` ← 1, state unchanged.
- `sym_comp` == 3 on a DC symbol: predictor 0 is used, `blk_comp`=0, `err` ← 1.
- Block closes: state ← OUT next cycle. `blk_line` and `blk_comp` stay stable until the handshake.
- OUT with `blk_valid && blk_ready`: line cleared to zero, `idx` ← 0, state ← FILL.
- `restart` clears the predictors:
  - On the same cycle as a DC accept, `restart` applies first; DC = 0 + diff, and the predictor stores diff.
  - `restart` does not abort a block in FILL or OUT.
- `reset` mid-block or in OUT: the partial block is discarded and all state returns to reset values.

## Timing
- One symbol per cycle in FILL; a ZRL or any run costs one cycle.
- Latency: the closing symbol is accepted at cycle N; `blk_valid`=1 at cycle N+1.
- `sym_ready`=0 throughout OUT, including the handshake cycle.
  - `sym_ready`=1 on the cycle after the handshake.
  - Minimum block period is k symbols + 1 cycle.
- `blk_ready` is ignored in FILL. `sym_valid` is ignored in OUT.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Add to `sys_defs.svh`:
  - typedef `COEFF_LINE` = `logic [`BLOCK_BUFF_SIZE-1:0][`Q-1:0]`
  - constants `NUM_COMP`=3, `ZRL_RUN`=15
- Sub-module `dc_predictor`: 3 Q-bit registers with a clear input (`restart`/`reset`) and an update port `{comp, diff}` → `dc`.
- The FILL/OUT control, `idx` counter and line register live in the top module.

## Test plan
- DC diff 5 (comp 0), AC run 0 coeff 3, AC run 2 coeff −1, EOB -> `blk_line[0]`=5, `[1]`=3, `[4]`=−1, all others 0; `blk_valid` the cycle after EOB; `err`=0.
- Two comp-0 blocks with DC diffs 5 then −2, then `restart`, then DC diff 7 -> DC values 5, 3, 7.
- DC, then ZRL ×3, then run 14 coeff 9 -> `line[63]`=9; block closes without EOB; `idx` wraps to 0 after handshake.
- DC, then AC run 15 coeff 1 ×4 -> last write (position 64) dropped; `err`=1; block emitted with `line[16,32,48]`=1.
- Block complete with `blk_ready` held 0 for 10 cycles -> `blk_line` stable, `sym_ready`=0; after handshake the next block starts all zero.
- `reset` asserted after 3 symbols, and EOB sent as the first symbol -> no `blk_valid`; EOB-first case sets `err`=1.
